usbsd_rvld_hs: RTL
==================

USBSD_RVLD_HS -- requirements
Module: usbsd_rvld_hs

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the width of the latched data byte and dev_data.
REQ-002 Parameter TIMEOUT_CYC, default 1024, SHALL set the handshake timeout in clk cycles per phase.
REQ-003 clk  input  1  SHALL be the single rising-edge clock.
REQ-004 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 rvld_in  input  1  SHALL be the read-valid level from the upstream PIO, synchronous to clk.
REQ-006 data_in  input  DATA_W  SHALL be the data byte, synchronous to clk and valid when rvld_in rises.
REQ-007 dev_req  output  1  SHALL be the registered request strobe to the USB/SD device.
REQ-008 dev_data  output  DATA_W  SHALL be the latched data presented to the device.
REQ-009 dev_ack  input  1  SHALL be the device acknowledge, asynchronous to clk.
REQ-010 address  input  2, chipselect  input  1, write_n  input  1, writedata  input  32  SHALL form the Avalon-MM slave write port.
REQ-011 readdata  output  32  SHALL be combinational read data selected by address.
REQ-012 irq  output  1  SHALL be the level interrupt to the CPU.

Function
REQ-013 dev_ack SHALL pass through a 2-flop synchronizer (ack_s); only ack_s SHALL be used internally.
REQ-014 A start SHALL occur when rvld_in=1, the previous-cycle sample of rvld_in was 0, and the FSM is in IDLE.
REQ-015 FSM states SHALL be IDLE, REQ, REL.
REQ-016 On a start, data_in SHALL be latched into dev_data, the FSM SHALL enter REQ, and dev_req SHALL be 1 from the next cycle.
REQ-017 In REQ, ack_s=1 SHALL move the FSM to REL, and dev_req SHALL be 0 from the next cycle.
REQ-018 In REL, ack_s=0 SHALL return the FSM to IDLE and set sticky status DONE.
REQ-019 A rising rvld_in seen outside IDLE SHALL be ignored for data and SHALL set sticky status OVR.
REQ-020 Status register (address 0) read SHALL return bit0 BUSY (state!=IDLE), bit1 DONE, bit2 OVR, bit3 TMO, and zeros elsewhere.
REQ-021 A write to address 0 SHALL clear each of DONE/OVR/TMO whose writedata bit is 1; a set and a clear in the same cycle SHALL leave the bit set.
REQ-022 Address 1 SHALL be a read/write IRQ-enable register, bits[2:0] for DONE/OVR/TMO, reset 0.
REQ-023 Address 2 SHALL read dev_data zero-extended; writes SHALL be ignored.
REQ-024 Address 3 SHALL read 0; writes SHALL be ignored.
REQ-025 irq SHALL equal the OR of ({TMO,OVR,DONE} AND enable[2:0]), registered with one cycle of latency.
REQ-026 Writes SHALL take effect only when chipselect=1 and write_n=0.

Reset
REQ-027 Reset SHALL force IDLE, dev_req=0, dev_data=0, synchronizer flops=0, previous rvld sample=0, all status bits=0, enables=0, irq=0.
REQ-028 Reset asserted mid-handshake SHALL drop dev_req immediately, with no DONE and no TMO recorded.

Configuration
REQ-029 With USBSD_HS_TIMEOUT_EN defined, a cycle counter SHALL clear on each entry to REQ or REL; when it reaches TIMEOUT_CYC-1 in either state, the FSM SHALL go to IDLE, dev_req SHALL drop on the next cycle, and TMO SHALL be set.
REQ-030 Without USBSD_HS_TIMEOUT_EN, no counter SHALL exist, REQ and REL SHALL wait indefinitely, and TMO SHALL read 0.

Structure
REQ-031 Package usbsd_pkg SHALL hold the state enum, the register address constants (STAT=0, IEN=1, DATA=2), and the status bit indices.
REQ-032 The synchronizer SHALL be the sub-module usbsd_sync2 (2-flop, async reset to 0).

Verification
REQ-033 Normal handshake: data_in=0xA5, rvld_in rises, ack raised 3 cycles after req and dropped 3 cycles after req falls -> dev_data=0xA5, req high from start+1, status reads 0x2 at the end.
REQ-034 Overrun: second rvld_in rise while in REQ with data_in=0x3C -> dev_data stays 0xA5 and status bit2=1.
REQ-035 Timeout (macro on, TIMEOUT_CYC=16): ack never rises -> req drops at 16 cycles into REQ and status reads 0x8; with macro off, req stays high for 1000 cycles.
REQ-036 IRQ: enable=0x1, complete a handshake -> irq=1 one cycle after DONE; write 0x2 to address 0 -> irq=0 one cycle later.
REQ-037 Set/clear collision: W1C of DONE in the same cycle as REL exits -> DONE remains 1.
REQ-038 Reset mid-REQ -> dev_req=0 immediately and status=0 after release.

Source files
------------

// File: rtl/usbsd_pkg.sv
// Shared types and constants for the USB/SD read-valid handshake bridge.
// State encoding, Avalon register map and status bit positions.
package usbsd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2
    } state_t;

    localparam logic [1:0] ADDR_STAT = 2'd0;
    localparam logic [1:0] ADDR_IEN  = 2'd1;
    localparam logic [1:0] ADDR_DATA = 2'd2;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_OVR  = 2;
    localparam int STAT_TMO  = 3;

endpackage

// File: rtl/usbsd_sync2.sv
// Two-flop synchronizer for a single asynchronous level; clears to 0 on reset.
module usbsd_sync2 (
    input  logic clk,
    input  logic reset_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/usbsd_rvld_hs.sv
// Turns a rising rvld_in into a four-phase req/ack handshake toward the device,
// with sticky status, IRQ enables and an optional per-phase timeout (USBSD_HS_TIMEOUT_EN).
module usbsd_rvld_hs
    import usbsd_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rvld_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              dev_req,
    output logic [DATA_W-1:0] dev_data,
    input  logic              dev_ack,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq,
    output state_t            o_dbg_state
);

    state_t              r_state;
    logic                r_dev_req;
    logic [DATA_W-1:0]   r_dev_data;
    logic                r_rvld_prev;
    logic                r_done;
    logic                r_ovr;
    logic                r_tmo;
    logic [2:0]          r_ien;
    logic                r_irq;

    logic                w_ack_s;
    logic                w_rise;
    logic                w_tmo_fire;
    logic                w_done_set;
    logic                w_ovr_set;
    logic                w_wr;
    logic                w_stat_wr;
    logic [31:0]         w_data_ext;
    logic                w_unused;

    usbsd_sync2 u_ack_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_d     (dev_ack),
        .o_q     (w_ack_s)
    );

    assign w_rise = rvld_in & ~r_rvld_prev;

`ifdef USBSD_HS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] r_cnt;

    // A normal exit always beats a timeout landing on the same cycle.
    assign w_tmo_fire = (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) &&
                        (((r_state == REQ) && !w_ack_s) || ((r_state == REL) && w_ack_s));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if ((r_state == IDLE) || w_tmo_fire || ((r_state == REQ) && w_ack_s)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
    assign w_tmo_fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_dev_req   <= 1'b0;
            r_dev_data  <= '0;
            r_rvld_prev <= 1'b0;
        end else begin
            r_rvld_prev <= rvld_in;
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_dev_data <= data_in;
                        r_dev_req  <= 1'b1;
                        r_state    <= REQ;
                    end
                end
                REQ: begin
                    if (w_ack_s) begin
                        r_dev_req <= 1'b0;
                        r_state   <= REL;
                    end else if (w_tmo_fire) begin
                        r_dev_req <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                REL: begin
                    if (!w_ack_s || w_tmo_fire) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_dev_req <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign w_done_set = (r_state == REL) && !w_ack_s;
    assign w_ovr_set  = w_rise && (r_state != IDLE);
    assign w_wr       = chipselect && !write_n;
    assign w_stat_wr  = w_wr && (address == ADDR_STAT);

    // Sticky bits: a set on the same edge as its W1C clear wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_done <= 1'b0;
            r_ovr  <= 1'b0;
            r_tmo  <= 1'b0;
            r_ien  <= 3'b000;
            r_irq  <= 1'b0;
        end else begin
            r_done <= w_done_set | (r_done & ~(w_stat_wr & writedata[STAT_DONE]));
            r_ovr  <= w_ovr_set  | (r_ovr  & ~(w_stat_wr & writedata[STAT_OVR]));
            r_tmo  <= w_tmo_fire | (r_tmo  & ~(w_stat_wr & writedata[STAT_TMO]));
            if (w_wr && (address == ADDR_IEN)) begin
                r_ien <= writedata[2:0];
            end
            r_irq  <= |({r_tmo, r_ovr, r_done} & r_ien);
        end
    end

    always_comb begin
        w_data_ext             = '0;
        w_data_ext[DATA_W-1:0] = r_dev_data;
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_STAT: begin
                readdata[STAT_BUSY] = (r_state != IDLE);
                readdata[STAT_DONE] = r_done;
                readdata[STAT_OVR]  = r_ovr;
                readdata[STAT_TMO]  = r_tmo;
            end
            ADDR_IEN:  readdata[2:0] = r_ien;
            ADDR_DATA: readdata = w_data_ext;
            default:   readdata = '0;
        endcase
    end

    assign w_unused    = ^{writedata[31:4], writedata[0]};
    assign dev_req     = r_dev_req;
    assign dev_data    = r_dev_data;
    assign irq         = r_irq;
    assign o_dbg_state = r_state;

endmodule
